// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: single-outstanding imem requests feeding a 2-entry {pc, instruction} queue.
// Optional FETCH_PERF_COUNTERS_EN adds push/drop event counters.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_shouldStall,
  input  logic        id_shouldJumpOrBranch,
  input  logic [31:0] id_jumpOrBranchPc,
  output logic        imem_request,
  output logic [31:0] imem_address,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_4
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] debug_fetchCount,
  output logic [31:0] debug_discardCount
`endif
);

  typedef enum logic [1:0] {FETCH, FULL, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        outstanding_q, outstanding_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pc_q [2];
  logic [31:0] pc_d [2];
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];
  logic        done, push, pop, drop, wr_hi;
  logic [31:0] redirect_pc;

  assign redirect_pc = id_jumpOrBranchPc & ~32'h3;

  // Outputs are forced to their reset values while reset is held, even before the first edge.
  always_comb begin
    imem_request   = !reset && (outstanding_q || (state_q != DISCARD && count_q < 2'd2));
    imem_address   = outstanding_q ? req_pc_q : fetch_pc_q;
    if_valid       = !reset && (count_q != 2'd0);
    if_instruction = if_valid ? instr_q[0] : '0;
    if_pc          = reset ? '0 : pc_q[0];
    if_pc_4        = if_pc + 32'd4;
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    done          = imem_request && imem_ready;
    outstanding_d = imem_request && !imem_ready;
    req_pc_d      = imem_address;
    push          = 1'b0;
    pop           = 1'b0;
    drop          = 1'b0;
    wr_hi         = 1'b0;

    if (id_shouldJumpOrBranch) begin
      // A request still waiting on memory must be held and its data discarded later.
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      drop       = done;
      state_d    = outstanding_d ? DISCARD : FETCH;
    end else if (state_q == DISCARD) begin
      drop = done;
      if (done) state_d = FETCH;
    end else begin
      pop   = if_valid && !id_shouldStall;
      push  = done;
      wr_hi = (count_q - {1'b0, pop}) != 2'd0;
      if (pop) begin
        pc_d[0]    = pc_q[1];
        instr_d[0] = instr_q[1];
      end
      if (push) begin
        if (wr_hi) begin
          pc_d[1]    = imem_address;
          instr_d[1] = imem_data;
        end else begin
          pc_d[0]    = imem_address;
          instr_d[0] = imem_data;
        end
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      state_d = (count_d == 2'd2 && !outstanding_d) ? FULL : FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FETCH;
      count_q       <= '0;
      outstanding_q <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q, discard_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      fetch_cnt_q   <= fetch_cnt_q + {31'd0, push};
      discard_cnt_q <= discard_cnt_q + {31'd0, drop};
    end
  end

  assign debug_fetchCount   = fetch_cnt_q;
  assign debug_discardCount = discard_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-based reference model of the fetch rules.
module tb_fetch_queue_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_shouldStall;
  logic        id_shouldJumpOrBranch;
  logic [31:0] id_jumpOrBranchPc;
  logic        imem_request;
  logic [31:0] imem_address;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] debug_fetchCount;
  logic [31:0] debug_discardCount;
`endif

  fetch_queue_unit #(.RESET_PC(RST_PC)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .id_shouldStall        (id_shouldStall),
    .id_shouldJumpOrBranch (id_shouldJumpOrBranch),
    .id_jumpOrBranchPc     (id_jumpOrBranchPc),
    .imem_request          (imem_request),
    .imem_address          (imem_address),
    .imem_ready            (imem_ready),
    .imem_data             (imem_data),
    .if_valid              (if_valid),
    .if_instruction        (if_instruction),
    .if_pc                 (if_pc),
    .if_pc_4               (if_pc_4)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .debug_fetchCount      (debug_fetchCount),
    .debug_discardCount    (debug_discardCount)
`endif
  );

  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the queue itself, the next fetch pc, and the one in-flight request.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fetch_pc;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  bit          m_dropping;
  logic [31:0] m_pushes;
  logic [31:0] m_drops;

  // {ready%, stall%, redirect%} per phase
  int unsigned phase_tab [8][3] = '{
    '{100, 0, 0}, '{100, 100, 0}, '{30, 0, 0}, '{60, 40, 10},
    '{20, 20, 25}, '{90, 10, 5}, '{50, 70, 15}, '{10, 0, 30}};

  initial begin
    bit          e_req, e_valid, done, pop;
    logic [31:0] e_addr, e_pc;
    int unsigned ph;
    int unsigned rst_left;

    reset = 1'b1;
    id_shouldStall = 1'b0;
    id_shouldJumpOrBranch = 1'b0;
    id_jumpOrBranchPc = '0;
    imem_ready = 1'b0;
    imem_data = '0;
    rst_left = 3;
    mq.delete();
    m_fetch_pc = RST_PC;
    m_pend = 0;
    m_pend_addr = '0;
    m_dropping = 0;
    m_pushes = '0;
    m_drops = '0;

    for (int cyc = 0; cyc < 3200; cyc++) begin
      @(negedge clock);
      ph = (cyc / 150) % 8;
      if (rst_left == 0 && cyc > 20 && $urandom_range(199) == 0) rst_left = $urandom_range(2, 1);
      reset = (rst_left != 0);
      if (rst_left != 0) rst_left--;

      e_req  = !reset && (m_pend || (!m_dropping && mq.size() < 2));
      e_addr = m_pend ? m_pend_addr : m_fetch_pc;
      e_valid = !reset && mq.size() > 0;

      id_shouldStall = ($urandom_range(99) < phase_tab[ph][1]);
      id_shouldJumpOrBranch = ($urandom_range(99) < phase_tab[ph][2]);
      case ($urandom_range(3))
        0:       id_jumpOrBranchPc = 32'h0000_0100 | $urandom_range(3);
        1:       id_jumpOrBranchPc = 32'hFFFF_FFF8 | $urandom_range(3);
        default: id_jumpOrBranchPc = $urandom;
      endcase
      imem_data = $urandom;
      // A real memory only answers a live request, but an in-flight reply may land during reset.
      imem_ready = ($urandom_range(99) < phase_tab[ph][0]) && (e_req || reset);

      #1;
      check_eq("imem_request", {31'd0, imem_request}, {31'd0, e_req});
      if (e_req) check_eq("imem_address", imem_address, e_addr);
      check_eq("if_valid", {31'd0, if_valid}, {31'd0, e_valid});
      check_eq("if_instruction", if_instruction, e_valid ? mq[0].instr : 32'h0);
      if (reset || e_valid) begin
        e_pc = reset ? 32'h0 : mq[0].pc;
        check_eq("if_pc", if_pc, e_pc);
        check_eq("if_pc_4", if_pc_4, e_pc + 32'd4);
      end
`ifdef FETCH_PERF_COUNTERS_EN
      if (!reset) begin
        check_eq("debug_fetchCount", debug_fetchCount, m_pushes);
        check_eq("debug_discardCount", debug_discardCount, m_drops);
      end
`endif

      @(posedge clock);
      if (reset) begin
        mq.delete();
        m_fetch_pc = RST_PC;
        m_pend = 0;
        m_dropping = 0;
        m_pushes = '0;
        m_drops = '0;
      end else begin
        done = e_req && imem_ready;
        pop  = e_valid && !id_shouldStall;
        if (id_shouldJumpOrBranch) begin
          if (done) m_drops++;
          mq.delete();
          m_fetch_pc = {id_jumpOrBranchPc[31:2], 2'b00};
          m_pend = e_req && !imem_ready;
          m_dropping = m_pend;
          m_pend_addr = e_addr;
        end else begin
          if (pop) void'(mq.pop_front());
          if (done) begin
            if (m_dropping) begin
              m_drops++;
              m_dropping = 0;
            end else begin
              mq.push_back('{pc: e_addr, instr: imem_data});
              m_fetch_pc = m_fetch_pc + 32'd4;
              m_pushes++;
            end
          end
          m_pend = e_req && !imem_ready;
          m_pend_addr = e_addr;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
